// File: rtl/bridge_req_arbiter_if.sv
// Request/issue/response signal bundle between requesters, the arbiter and the host.
// The arbiter connects through the slave modport; the requester/host side uses master.
interface bridge_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_cmd;
    logic [32*NUM_REQ-1:0] req_param;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [7:0]            rsp_result;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [15:0]           issue_cmd;
    logic [31:0]           issue_param;
    logic                  host_done;
    logic [7:0]            host_result;
    logic                  busy;

    modport slave (
        input  req_valid, req_cmd, req_param, issue_ready, host_done, host_result,
        output req_ack, rsp_valid, rsp_result, issue_valid, issue_cmd, issue_param, busy
    );

    modport master (
        output req_valid, req_cmd, req_param, issue_ready, host_done, host_result,
        input  req_ack, rsp_valid, rsp_result, issue_valid, issue_cmd, issue_param, busy
    );
endinterface

// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter that forwards one requester's command downstream, waits for the
// host result (or a timeout), and returns the result to the granted requester.
module bridge_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    bridge_req_arbiter_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [TMR_W-1:0] r_timer;
    logic             r_first;
    logic [15:0]      r_cmd;
    logic [31:0]      r_param;
    logic [7:0]       r_result;

    logic             w_found;
    logic [IDX_W-1:0] w_sel;
    logic [15:0]      w_cmd;
    logic [31:0]      w_param;

    // Distances are scanned farthest-first so the nearest requester after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cmd   = '0;
        w_param = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && (i == (int'(r_ptr) + k) % NUM_REQ)) begin
                    w_found = 1'b1;
                    w_sel   = IDX_W'(i);
                    w_cmd   = bus.req_cmd[16*i +: 16];
                    w_param = bus.req_param[32*i +: 32];
                end
            end
        end
    end

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        w_next          = r_state;
        bus.req_ack     = '0;
        bus.rsp_valid   = '0;
        bus.issue_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) w_next = ISSUE;
            end
            ISSUE: begin
                bus.issue_valid = 1'b1;
                if (r_first) bus.req_ack[r_grant] = 1'b1;
                if (bus.issue_ready) w_next = WAIT;
            end
            WAIT: begin
                if (bus.host_done || (r_timer == TMR_LAST)) w_next = RESPOND;
            end
            RESPOND: begin
                bus.rsp_valid[r_grant] = 1'b1;
                w_next                 = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_grant  <= '0;
            r_timer  <= '0;
            r_first  <= 1'b0;
            r_cmd    <= '0;
            r_param  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_cmd   <= w_cmd;
                        r_param <= w_param;
                        r_first <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_first <= 1'b0;
                    if (bus.issue_ready) r_timer <= '0;
                end
                WAIT: begin
                    r_timer <= r_timer + TMR_W'(1);
                    // A late host completion beats the timeout code.
                    if (bus.host_done) r_result <= bus.host_result;
                    else if (r_timer == TMR_LAST) r_result <= 8'hFF;
                end
                RESPOND: r_ptr <= r_grant;
                default: ;
            endcase
        end
    end

    assign bus.rsp_result  = r_result;
    assign bus.issue_cmd   = r_cmd;
    assign bus.issue_param = r_param;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Scoreboard bench for bridge_req_arbiter: directed stimulus pushes expected acks and
// responses; a negedge monitor pops and compares whenever the DUT pulses them.
module tb_bridge_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TOUT    = 8;

    typedef struct {
        int          idx;
        logic [15:0] cmd;
        logic [31:0] param;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        int         idx;
        logic [7:0] res;
        int         cyc;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c0;

    ack_exp_t ack_q[$];
    rsp_exp_t rsp_q[$];
    ack_exp_t ae;
    rsp_exp_t re;

    bridge_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    bridge_req_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] cmd, input logic [31:0] param);
        bus.req_cmd[16*i +: 16]   = cmd;
        bus.req_param[32*i +: 32] = param;
    endtask

    task automatic push_ack(input int i, input logic [15:0] cmd, input logic [31:0] param,
                            input int c);
        ack_exp_t e;
        e.idx = i; e.cmd = cmd; e.param = param; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic push_rsp(input int i, input logic [7:0] res, input int c);
        rsp_exp_t e;
        e.idx = i; e.res = res; e.cyc = c;
        rsp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(bus.req_ack), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_result"}, 32'(bus.rsp_result), 0);
        check({tag, "_issue_valid"}, 32'(bus.issue_valid), 0);
        check({tag, "_issue_cmd"}, 32'(bus.issue_cmd), 0);
        check({tag, "_issue_param"}, bus.issue_param, 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    // Monitor: every ack/response pulse must match the head of its queue.
    always @(negedge clk) begin
        if (bus.req_ack != '0) begin
            check("ack_onehot", 32'($onehot(bus.req_ack)), 1);
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(bus.req_ack), 0);
            end else begin
                ae = ack_q.pop_front();
                check("ack_idx", 32'(bus.req_ack), 32'(1) << ae.idx);
                check("ack_issue_cmd", 32'(bus.issue_cmd), 32'(ae.cmd));
                check("ack_issue_param", bus.issue_param, ae.param);
                check("ack_issue_valid", 32'(bus.issue_valid), 1);
                if (ae.cyc >= 0) check("ack_cycle", cyc, ae.cyc);
            end
        end
        if (bus.rsp_valid != '0) begin
            check("rsp_onehot", 32'($onehot(bus.rsp_valid)), 1);
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 0);
            end else begin
                re = rsp_q.pop_front();
                check("rsp_idx", 32'(bus.rsp_valid), 32'(1) << re.idx);
                check("rsp_result", 32'(bus.rsp_result), 32'(re.res));
                if (re.cyc >= 0) check("rsp_cycle", cyc, re.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_cmd     = '0;
        bus.req_param   = '0;
        bus.issue_ready = 1'b0;
        bus.host_done   = 1'b0;
        bus.host_result = '0;

        // Reset: outputs cleared even with a request pending.
        reset = 1'b1;
        bus.req_valid = 4'b0001;
        tick(); tick();
        check_all_zero("rst");
        bus.req_valid = '0;
        reset = 1'b0;
        tick();

        // Single request from requester 2 at minimum latency.
        bus.issue_ready = 1'b1;
        set_req(2, 16'h0080, 32'h0000_1234);
        bus.req_valid = 4'b0100;
        c0 = cyc;
        push_ack(2, 16'h0080, 32'h0000_1234, c0 + 1);
        push_rsp(2, 8'h00, c0 + 3);
        tick();
        check("single_busy_issue", 32'(bus.busy), 1);
        bus.req_valid = '0;
        tick();
        check("single_wait_no_issue", 32'(bus.issue_valid), 0);
        bus.host_done   = 1'b1;
        bus.host_result = 8'h00;
        tick();
        bus.host_done = 1'b0;
        tick();
        check("single_idle_busy", 32'(bus.busy), 0);
        tick();

        // Round-robin with requesters 0, 1, 3; requester 0 comes back after its grant.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h0100 + 16'(i), 32'hA000_0000 + i);
        push_ack(0, 16'h0100, 32'hA000_0000, -1); push_rsp(0, 8'h10, -1);
        push_ack(1, 16'h0101, 32'hA000_0001, -1); push_rsp(1, 8'h11, -1);
        push_ack(3, 16'h0103, 32'hA000_0003, -1); push_rsp(3, 8'h12, -1);
        push_ack(0, 16'h0100, 32'hA000_0000, -1); push_rsp(0, 8'h13, -1);
        bus.issue_ready = 1'b1;
        bus.req_valid   = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            for (int t = 0; t < 20 && bus.req_ack == '0; t++) tick();
            check("rr_ack_seen", 32'(bus.req_ack != '0), 1);
            bus.req_valid = bus.req_valid & ~bus.req_ack;
            tick();
            if (n == 0) bus.req_valid[0] = 1'b1;
            bus.host_done   = 1'b1;
            bus.host_result = 8'h10 + 8'(n);
            tick();
            bus.host_done = 1'b0;
        end
        tick(); tick();

        // Timeout; host_done during ISSUE must be ignored.
        set_req(1, 16'h0C01, 32'h0000_C001);
        bus.issue_ready = 1'b0;
        bus.req_valid   = 4'b0010;
        c0 = cyc;
        push_ack(1, 16'h0C01, 32'h0000_C001, c0 + 1);
        push_rsp(1, 8'hFF, c0 + 4 + TOUT);
        tick();
        bus.req_valid   = '0;
        bus.host_done   = 1'b1;
        bus.host_result = 8'h55;
        tick(); tick();
        bus.host_done   = 1'b0;
        bus.issue_ready = 1'b1;
        repeat (11) tick();

        // host_done in the timeout cycle beats 8'hFF.
        set_req(1, 16'h0D01, 32'h0000_D001);
        bus.req_valid = 4'b0010;
        c0 = cyc;
        push_ack(1, 16'h0D01, 32'h0000_D001, c0 + 1);
        push_rsp(1, 8'h03, c0 + 2 + TOUT);
        tick();
        bus.req_valid = '0;
        repeat (TOUT) tick();
        bus.host_done   = 1'b1;
        bus.host_result = 8'h03;
        tick();
        bus.host_done = 1'b0;
        tick(); tick();
        check("late_done_hold", 32'(bus.rsp_result), 32'h03);
        check("late_done_idle", 32'(bus.busy), 0);

        // Backpressure: fields stay stable while input words change underneath.
        set_req(3, 16'hBEEF, 32'hDEAD_BEEF);
        bus.issue_ready = 1'b0;
        bus.req_valid   = 4'b1000;
        c0 = cyc;
        push_ack(3, 16'hBEEF, 32'hDEAD_BEEF, c0 + 1);
        tick();
        bus.req_valid = '0;
        set_req(3, 16'h1111, 32'h2222_2222);
        for (int t = 0; t < 20; t++) begin
            check("bp_issue_valid", 32'(bus.issue_valid), 1);
            check("bp_issue_cmd", 32'(bus.issue_cmd), 32'hBEEF);
            check("bp_issue_param", bus.issue_param, 32'hDEAD_BEEF);
            tick();
        end
        bus.issue_ready = 1'b1;
        tick(); tick();
        check("bp_in_wait", 32'(bus.busy), 1);

        // Reset in WAIT: transaction dropped, no response.
        reset = 1'b1;
        tick();
        check_all_zero("rst_wait");
        tick();
        reset = 1'b0;

        // After reset requester 0 wins over 2 and 3.
        set_req(0, 16'h00A0, 32'h0000_00A0);
        bus.req_valid = 4'b1101;
        c0 = cyc;
        push_ack(0, 16'h00A0, 32'h0000_00A0, c0 + 1);
        push_rsp(0, 8'h42, c0 + 3);
        tick();
        bus.req_valid = '0;
        tick();
        bus.host_done   = 1'b1;
        bus.host_result = 8'h42;
        tick();
        bus.host_done = 1'b0;
        tick(); tick();

        check("ack_queue_drained", ack_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bridge_req_arbiter.md
BRIDGE_REQ_ARBITER -- requirements
Module: bridge_req_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT cycles before a forced response, at least 2.
REQ-004 clk  in  1  the block's single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester request; held until that requester's req_ack.
REQ-007 req_cmd  in  16*NUM_REQ  command word; slice i belongs to requester i.
REQ-008 req_param  in  32*NUM_REQ  parameter word; slice i belongs to requester i.
REQ-009 req_ack  out  NUM_REQ  one-cycle pulse: request captured.
REQ-010 rsp_valid  out  NUM_REQ  one-cycle pulse: rsp_result is valid for that requester.
REQ-011 rsp_result  out  8  result code, shared by all requesters.
REQ-012 issue_valid  out  1  command offered downstream.
REQ-013 issue_ready  in  1  downstream accepts the command.
REQ-014 issue_cmd  out  16  captured command.
REQ-015 issue_param  out  32  captured parameter.
REQ-016 host_done  in  1  host completion strobe.
REQ-017 host_result  in  8  host result; qualified by host_done.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESPOND.
REQ-020 IDLE: the block SHALL select the first set req_valid bit, searching upward from (ptr+1) mod NUM_REQ with wrap-around.
REQ-021 On that selection the block SHALL register the grant index, req_cmd and req_param, then go to ISSUE.
REQ-022 IDLE with no req_valid set: the block SHALL stay in IDLE.
REQ-023 ISSUE: issue_valid SHALL be 1, with issue_cmd and issue_param stable.
REQ-024 req_ack[grant] SHALL be 1 only in the first ISSUE cycle.
REQ-025 ISSUE: issue_ready sampled 1 SHALL move the FSM to WAIT and clear the timer; otherwise the FSM stays in ISSUE indefinitely.
REQ-026 WAIT: the timer SHALL increment by one per cycle and be clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-027 WAIT with host_done=1: the block SHALL capture host_result into rsp_result and go to RESPOND.
REQ-028 WAIT with host_done=0 and timer==TIMEOUT_CYCLES-1: the block SHALL set rsp_result=8'hFF and go to RESPOND.
REQ-029 host_done in the timeout cycle SHALL win: host_result is used, not 8'hFF.
REQ-030 host_done outside WAIT SHALL be ignored.
REQ-031 RESPOND: rsp_valid[grant] SHALL be 1 for exactly one cycle, then ptr := grant and the FSM goes to IDLE.
REQ-032 rsp_result SHALL hold its value until the next RESPOND.
REQ-033 Minimum latency, with issue_ready=1 and host_done in the first WAIT cycle:
- req_valid sampled in IDLE at cycle 0;
- ack and issue_valid in cycle 1;
- WAIT in cycle 2;
- rsp_valid in cycle 3;
- IDLE in cycle 4.
REQ-034 req_valid changes while not in IDLE SHALL have no effect.
REQ-035 A requester still asserting req_valid on return to IDLE SHALL be re-arbitrated as a new request.
REQ-036 At most one req_ack bit and one rsp_valid bit SHALL be set in any cycle.

Reset
REQ-037 While reset is high, on each rising clk edge the block SHALL set: state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), timer=0.
REQ-038 While reset is high, on each rising clk edge the block SHALL also set: req_ack=0, rsp_valid=0, rsp_result=0, issue_valid=0, issue_cmd=0, issue_param=0, busy=0.
REQ-039 Reset during ISSUE or WAIT SHALL abandon the transaction and emit no rsp_valid.

Verification
REQ-040 Single request: requester 2 sends cmd 16'h0080, param 32'h1234; issue_ready=1; host_done with result 8'h00 two cycles later.
- Required: req_ack=4'b0100 once; issue_cmd=16'h0080; rsp_valid=4'b0100; rsp_result=8'h00.
REQ-041 Round-robin: requesters 0, 1 and 3 all held valid, each released on its ack.
- Required: grant order 0, 1, 3, then 0 again if requester 0 re-requests.
REQ-042 Timeout: TIMEOUT_CYCLES=8, host_done never asserted.
- Required: rsp_valid exactly 8 cycles after entry to WAIT; rsp_result=8'hFF.
REQ-043 host_done with result 8'h03 in the timeout cycle.
- Required: rsp_result=8'h03.
REQ-044 Backpressure and reset:
- issue_ready=0 for 20 cycles: issue_valid and issue fields stay stable.
- Reset asserted during WAIT: all outputs 0 and no rsp_valid.
- After reset: requester 0 is granted first.
